// File: rtl/enc_mac_if.sv
// enc_mac_if: bundle between encoder-stage requesters / result consumer and
// the shared MAC scheduler.
//   req_valid/req_ready : per-requester job handshake (ready is one-hot)
//   req_x/req_w/req_b   : flattened operands of every requester
//   y/y_valid/y_ready   : result handshake, y_id names the owning requester
//   busy                : scheduler is working on or holding a job
// Modports: master = requesters plus consumer, slave = scheduler.
interface enc_mac_if #(
  parameter int BITSIZE = 16,
  parameter int N_IN    = 6,
  parameter int N_OUT   = 2,
  parameter int NREQ    = 2
);
  localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]                    req_valid;
  logic [NREQ-1:0]                    req_ready;
  logic [NREQ*N_IN*BITSIZE-1:0]       req_x;
  logic [NREQ*N_IN*N_OUT*BITSIZE-1:0] req_w;
  logic [NREQ*N_OUT*BITSIZE-1:0]      req_b;
  logic [N_OUT*BITSIZE-1:0]           y;
  logic                               y_valid;
  logic [ID_W-1:0]                    y_id;
  logic                               y_ready;
  logic                               busy;

  modport master (
    output req_valid, req_x, req_w, req_b, y_ready,
    input  req_ready, y, y_valid, y_id, busy
  );

  modport slave (
    input  req_valid, req_x, req_w, req_b, y_ready,
    output req_ready, y, y_valid, y_id, busy
  );
endinterface

// File: rtl/enc_mac_scheduler.sv
// enc_mac_scheduler: round-robin arbiter in front of one time-multiplexed
// dense-layer MAC engine (y = W*x + b, N_OUT lanes, one input element per
// cycle). A granted job's operands are captured at the handshake, N_IN MAC
// cycles follow, and the result is held on y until the consumer takes it.
// Ports:
//   clk   : clock
//   reset : asynchronous, active-high
//   bus   : enc_mac_if slave (requests, operands, result handshake, busy)
module enc_mac_scheduler #(
  parameter int BITSIZE = 16,
  parameter int FRAC    = 8,
  parameter int N_IN    = 6,
  parameter int N_OUT   = 2,
  parameter int NREQ    = 2
) (
  input  logic     clk,
  input  logic     reset,
  enc_mac_if.slave bus
);
  localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int K_W  = (N_IN > 1) ? $clog2(N_IN) : 1;

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  state_t                    state;
  logic [ID_W-1:0]           ptr;
  logic [ID_W-1:0]           y_id_r;
  logic [K_W-1:0]            k;
  logic [N_OUT*BITSIZE-1:0]  y_r;
  logic                      y_valid_r;

  logic                      gnt_found;
  logic [ID_W-1:0]           gnt_id;
  logic                      hs;

  logic signed [BITSIZE-1:0] x_r     [N_IN];
  logic signed [BITSIZE-1:0] w_r     [N_IN][N_OUT];
  logic signed [BITSIZE-1:0] acc     [N_OUT];
  logic signed [BITSIZE-1:0] acc_nxt [N_OUT];
  logic [N_OUT*BITSIZE-1:0]  acc_nxt_flat;

  logic signed [BITSIZE-1:0] sel_x   [N_IN];
  logic signed [BITSIZE-1:0] sel_w   [N_IN][N_OUT];
  logic signed [BITSIZE-1:0] sel_b   [N_OUT];

  // Fixed-point product: full-width signed multiply, arithmetic shift by
  // FRAC, keep the low BITSIZE bits (no rounding, no saturation).
  function automatic logic signed [BITSIZE-1:0] mul(
    input logic signed [BITSIZE-1:0] a,
    input logic signed [BITSIZE-1:0] b
  );
    logic signed [2*BITSIZE-1:0] ea;
    logic signed [2*BITSIZE-1:0] eb;
    logic signed [2*BITSIZE-1:0] prod;
    ea   = {{BITSIZE{a[BITSIZE-1]}}, a};
    eb   = {{BITSIZE{b[BITSIZE-1]}}, b};
    prod = ea * eb;
    return BITSIZE'(prod >>> FRAC);
  endfunction

  // Round-robin search: first requester at or above the pointer, otherwise
  // wrap around and take the lowest requesting index.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (!gnt_found && bus.req_valid[j] && (ID_W'(j) >= ptr)) begin
        gnt_found = 1'b1;
        gnt_id    = ID_W'(j);
      end
    end
    for (int j = 0; j < NREQ; j++) begin
      if (!gnt_found && bus.req_valid[j]) begin
        gnt_found = 1'b1;
        gnt_id    = ID_W'(j);
      end
    end
  end

  // Grant is combinational and only offered in IDLE; held low during reset
  // so no handshake can be observed while the block is being cleared.
  always_comb begin
    bus.req_ready = '0;
    for (int j = 0; j < NREQ; j++) begin
      bus.req_ready[j] = !reset && (state == IDLE) && gnt_found &&
                         (gnt_id == ID_W'(j));
    end
  end

  assign hs = |bus.req_ready;

  // Operand mux: pick the granted requester's slices out of the flat buses.
  always_comb begin
    sel_x = '{default: '0};
    sel_w = '{default: '{default: '0}};
    sel_b = '{default: '0};
    for (int r = 0; r < NREQ; r++) begin
      if (gnt_id == ID_W'(r)) begin
        for (int kk = 0; kk < N_IN; kk++) begin
          sel_x[kk] = bus.req_x[(r*N_IN+kk)*BITSIZE +: BITSIZE];
          for (int l = 0; l < N_OUT; l++) begin
            sel_w[kk][l] = bus.req_w[((r*N_IN+kk)*N_OUT+l)*BITSIZE +: BITSIZE];
          end
        end
        for (int l = 0; l < N_OUT; l++) begin
          sel_b[l] = bus.req_b[(r*N_OUT+l)*BITSIZE +: BITSIZE];
        end
      end
    end
  end

  always_comb begin
    acc_nxt_flat = '0;
    for (int l = 0; l < N_OUT; l++) begin
      acc_nxt[l] = acc[l] + mul(x_r[k], w_r[k][l]);
      acc_nxt_flat[l*BITSIZE +: BITSIZE] = acc_nxt[l];
    end
  end

  // Operand capture at the handshake edge; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (hs) begin
      x_r <= sel_x;
      w_r <= sel_w;
    end
  end

  // Control FSM plus accumulators and held result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      k         <= '0;
      y_id_r    <= '0;
      y_r       <= '0;
      y_valid_r <= 1'b0;
      acc       <= '{default: '0};
    end else begin
      case (state)
        IDLE: begin
          if (hs) begin
            acc    <= sel_b;
            k      <= '0;
            y_id_r <= gnt_id;
            state  <= MAC;
          end
        end
        MAC: begin
          acc <= acc_nxt;
          if (k == K_W'(N_IN-1)) begin
            k         <= '0;
            y_r       <= acc_nxt_flat;
            y_valid_r <= 1'b1;
            state     <= DONE;
          end else begin
            k <= k + 1'b1;
          end
        end
        DONE: begin
          if (bus.y_ready) begin
            y_valid_r <= 1'b0;
            ptr       <= (int'(y_id_r) == NREQ-1) ? '0 : y_id_r + 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.y       = y_r;
  assign bus.y_valid = y_valid_r;
  assign bus.y_id    = y_id_r;
  assign bus.busy    = (state != IDLE);
endmodule
